// File: rtl/window_convolver_if.sv
// Bundles the window-reader input, the kernel write port and the result outputs of window_convolver.
// Latency: none; this is only a signal bundle.
// Backpressure: none; the master drives the window and kernel, and the slave answers with a one-cycle valid pulse.
// Ports (master view): Conv_Window/Conv_WinRdy is the window and its ready level; Conv_KWe/Conv_KAddr/Conv_KData is the
//                      coefficient write; Conv_Result/Conv_Valid/Conv_Busy is the result and the block status.
interface window_convolver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 3,
    parameter int COEF_WIDTH = 8
);
    logic [DATA_WIDTH*WINDOW*WINDOW-1:0] Conv_Window;
    logic                                Conv_WinRdy;
    logic                                Conv_KWe;
    logic [3:0]                          Conv_KAddr;
    logic [COEF_WIDTH-1:0]               Conv_KData;
    logic [DATA_WIDTH-1:0]               Conv_Result;
    logic                                Conv_Valid;
    logic                                Conv_Busy;

    modport master (
        output Conv_Window, Conv_WinRdy, Conv_KWe, Conv_KAddr, Conv_KData,
        input  Conv_Result, Conv_Valid, Conv_Busy
    );

    modport slave (
        input  Conv_Window, Conv_WinRdy, Conv_KWe, Conv_KAddr, Conv_KData,
        output Conv_Result, Conv_Valid, Conv_Busy
    );
endinterface

// File: rtl/window_convolver.sv
// Convolves a captured WINDOW x WINDOW pixel window with a programmable signed kernel, then shifts and clamps the sum.
// Latency: the result and a Valid pulse arrive WINDOW*WINDOW+1 cycles after the Conv_WinRdy rising edge is captured.
// Backpressure: none; while Busy is high, new window edges and kernel writes are dropped.
// Ports: Conv_CLK is the clock; Conv_RST_N is the async active-low reset; bus is the slave side of window_convolver_if
//        (window, ready level, kernel write port, result, valid and busy).
module window_convolver #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 3,
    parameter int COEF_WIDTH = 8,
    parameter int SHIFT      = 4
) (
    input  logic              Conv_CLK,
    input  logic              Conv_RST_N,
    window_convolver_if.slave bus
);
    localparam int N      = WINDOW * WINDOW;
    // The product of a (DATA_WIDTH+1)-bit signed pixel and a coefficient needs DATA+COEF+1 bits.
    // The 4-bit kernel address caps N at 16, so 4 more bits hold the full sum without overflow.
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + 5;
    localparam int CENTER = (WINDOW / 2) * WINDOW + (WINDOW / 2);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                       state;
    logic [DATA_WIDTH*N-1:0]      win_q;
    logic signed [COEF_WIDTH-1:0] coef [N];
    logic signed [ACC_W-1:0]      acc;
    logic [3:0]                   idx;
    logic                         rdy_prev;
    logic [DATA_WIDTH-1:0]        result_q;
    logic                         valid_q;
    logic                         busy_q;

    logic [DATA_WIDTH-1:0]        pix_sel;
    logic signed [COEF_WIDTH-1:0] coef_sel;
    logic signed [PROD_W-1:0]     pix_ext;
    logic signed [PROD_W-1:0]     coef_ext;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      shifted;
    logic [DATA_WIDTH-1:0]        clamped;
    logic                         win_edge;

    always_comb begin
        pix_sel  = '0;
        coef_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == 4'(i)) begin
                pix_sel  = win_q[i*DATA_WIDTH +: DATA_WIDTH];
                coef_sel = coef[i];
            end
        end
        // Pixels are unsigned, so zero-extend them. Coefficients are signed, so sign-extend them.
        // Both operands are extended to the product width so the multiply is signed at full width.
        pix_ext  = {{(COEF_WIDTH + 1){1'b0}}, pix_sel};
        coef_ext = {{(DATA_WIDTH + 1){coef_sel[COEF_WIDTH-1]}}, coef_sel};
        prod     = pix_ext * coef_ext;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

        shifted  = acc >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            clamped = '0;
        end else if (|shifted[ACC_W-2:DATA_WIDTH]) begin
            clamped = '1;
        end else begin
            clamped = shifted[DATA_WIDTH-1:0];
        end

        win_edge = bus.Conv_WinRdy & ~rdy_prev;
    end

    // The kernel is writable only while idle, so a result is never built from a kernel that changed part-way through.
    always_ff @(posedge Conv_CLK or negedge Conv_RST_N) begin
        if (!Conv_RST_N) begin
            for (int i = 0; i < N; i++) begin
                coef[i] <= (i == CENTER) ? COEF_WIDTH'(1 << SHIFT) : '0;
            end
        end else if (bus.Conv_KWe && !busy_q) begin
            for (int i = 0; i < N; i++) begin
                if (bus.Conv_KAddr == 4'(i)) begin
                    coef[i] <= bus.Conv_KData;
                end
            end
        end
    end

    always_ff @(posedge Conv_CLK or negedge Conv_RST_N) begin
        if (!Conv_RST_N) begin
            state    <= IDLE;
            win_q    <= '0;
            acc      <= '0;
            idx      <= '0;
            rdy_prev <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // The ready history updates in every state. A level held through a busy period
            // therefore does not look like a fresh edge once the block is idle again.
            rdy_prev <= bus.Conv_WinRdy;
            valid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_edge) begin
                        win_q  <= bus.Conv_Window;
                        acc    <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + 4'd1;
                    if (idx == 4'(N - 1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    result_q <= clamped;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Conv_Result = result_q;
    assign bus.Conv_Valid  = valid_q;
    assign bus.Conv_Busy   = busy_q;
endmodule

// File: tb/tb_window_convolver.sv
// Self-checking bench for window_convolver. It applies a vector table and a few hand-written corner-case sequences,
// and a scoreboard checks each result and its latency.
module tb_window_convolver;
    localparam int DW = 16;
    localparam int W  = 3;
    localparam int CW = 8;
    localparam int N  = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_convolver_if #(.DATA_WIDTH(DW), .WINDOW(W), .COEF_WIDTH(CW)) bus ();

    window_convolver #(.DATA_WIDTH(DW), .WINDOW(W), .COEF_WIDTH(CW), .SHIFT(4)) dut (
        .Conv_CLK   (clk),
        .Conv_RST_N (rst_n),
        .bus        (bus)
    );

    typedef struct packed {
        logic               write_k;
        logic [8:0][7:0]    k;
        logic [8:0][15:0]   win;
        logic [15:0]        exp_res;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [31:0] cyc;
    } sb_t;

    vec_t vecs [7];
    sb_t  sbq [$];
    sb_t  mon_item;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_valid = 0;
    int   cyc     = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every Valid pulse must match a pending expectation in both value and cycle, and must last one cycle.
    always @(negedge clk) begin
        if (prev_valid) check("valid_one_cycle", 32'(bus.Conv_Valid), 32'd0);
        if (bus.Conv_Valid) begin
            n_valid++;
            check("valid_has_pending", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                mon_item = sbq.pop_front();
                check("result_value", 32'(bus.Conv_Result), 32'(mon_item.res));
                check("valid_latency", 32'(cyc), mon_item.cyc);
            end
        end
        prev_valid = bus.Conv_Valid;
    end

    task automatic load_kernel(input logic [8:0][7:0] k);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.Conv_KWe   = 1'b1;
            bus.Conv_KAddr = 4'(i);
            bus.Conv_KData = k[i];
        end
        @(negedge clk);
        bus.Conv_KWe = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.Conv_Busy && sbq.size() == 0) break;
        end
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        check("idle_after_result", 32'(bus.Conv_Busy), 32'd0);
    endtask

    task automatic run_window(input logic [8:0][15:0] w, input logic [15:0] e);
        @(negedge clk);
        bus.Conv_Window = w;
        bus.Conv_WinRdy = 1'b1;
        sbq.push_back('{res: e, cyc: 32'(cyc + 11)});
        @(negedge clk);
        check("busy_after_capture", 32'(bus.Conv_Busy), 32'd1);
        bus.Conv_Window = ~w;           // must not disturb the captured window
        repeat (2) @(negedge clk);
        bus.Conv_WinRdy = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0][7:0]  k;
        logic [8:0][15:0] w;
        int               v0;

        bus.Conv_Window = '0;
        bus.Conv_WinRdy = 1'b0;
        bus.Conv_KWe    = 1'b0;
        bus.Conv_KAddr  = '0;
        bus.Conv_KData  = '0;

        // Vector table. Entry 0 relies on the identity kernel loaded by reset.
        for (int v = 0; v < 7; v++) begin
            vecs[v] = '0;
            vecs[v].write_k = (v != 0);
        end
        for (int i = 0; i < N; i++) begin
            vecs[0].win[i] = 16'hFFFF;
            vecs[1].k[i] = 8'd2;    vecs[1].win[i] = 16'h0100;
            vecs[2].k[i] = 8'd0;    vecs[2].win[i] = 16'h7777;
            vecs[3].k[i] = 8'd127;  vecs[3].win[i] = 16'hFFFF;
            vecs[4].k[i] = (i % 2 == 0) ? 8'(i + 1) : 8'(-(i + 1));
            vecs[4].win[i] = 16'((i + 1) * 16);
            vecs[5].k[i] = 8'd0;    vecs[5].win[i] = 16'h5555;
            vecs[6].k[i] = 8'd0;    vecs[6].win[i] = 16'hABCD;
        end
        vecs[0].win[4] = 16'h1234; vecs[0].exp_res = 16'h1234;
        vecs[1].exp_res = 16'h0120;
        vecs[2].k[4] = 8'hF0; vecs[2].win[4] = 16'h0005; vecs[2].exp_res = 16'h0000;
        vecs[3].exp_res = 16'hFFFF;
        vecs[4].exp_res = 16'h002D;     // 16*(1-4+9-16+25-36+49-64+81) >> 4 = 45
        vecs[5].k[0] = 8'h80; vecs[5].win[0] = 16'h0001;
        vecs[5].k[8] = 8'd127; vecs[5].win[8] = 16'h1000;
        vecs[5].exp_res = 16'h7EF8;     // (-128 + 127*4096) >> 4 = 32504
        vecs[6].k[4] = 8'd1; vecs[6].win[4] = 16'h001F; vecs[6].exp_res = 16'h0001;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_result", 32'(bus.Conv_Result), 32'd0);
        check("reset_valid", 32'(bus.Conv_Valid), 32'd0);
        check("reset_busy", 32'(bus.Conv_Busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].write_k) load_kernel(vecs[v].k);
            run_window(vecs[v].win, vecs[v].exp_res);
        end

        // Sequence A: a second ready edge and a kernel write during busy are both dropped,
        // and a ready level held across the return to idle does not retrigger.
        for (int i = 0; i < N; i++) k[i] = (i == 4) ? 8'd16 : 8'd0;
        load_kernel(k);
        for (int i = 0; i < N; i++) w[i] = (i == 4) ? 16'h0ABC : 16'h1111;
        v0 = n_valid;
        @(negedge clk);                                  // before edge E
        bus.Conv_Window = w;
        bus.Conv_WinRdy = 1'b1;
        sbq.push_back('{res: 16'h0ABC, cyc: 32'(cyc + 11)});
        @(negedge clk);                                  // after E
        bus.Conv_WinRdy = 1'b0;
        repeat (2) @(negedge clk);                       // after E+2
        bus.Conv_KWe    = 1'b1;                          // sampled at E+3
        bus.Conv_KAddr  = 4'd4;
        bus.Conv_KData  = 8'h7F;
        bus.Conv_WinRdy = 1'b1;                          // rising edge while busy
        @(negedge clk);
        bus.Conv_KWe = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);                      // ready is still high here
        check("seqA_single_valid", 32'(n_valid - v0), 32'd1);
        check("seqA_no_retrigger_busy", 32'(bus.Conv_Busy), 32'd0);
        bus.Conv_WinRdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) w[i] = (i == 4) ? 16'h0100 : 16'h2222;
        run_window(w, 16'h0100);                         // coefficient 4 must still be 16

        // Sequence B: a reset during MAC aborts the operation and restores the identity kernel.
        // A ready level that is still high afterwards starts a new operation.
        for (int i = 0; i < N; i++) k[i] = 8'd2;
        load_kernel(k);
        for (int i = 0; i < N; i++) w[i] = (i == 4) ? 16'h0321 : 16'h0010;
        v0 = n_valid;
        @(negedge clk);
        bus.Conv_Window = w;
        bus.Conv_WinRdy = 1'b1;                          // capture at E, no result expected
        repeat (5) @(negedge clk);                       // after E+4
        @(posedge clk);                                  // E+5
        #2 rst_n = 1'b0;
        #1;
        check("seqB_reset_busy", 32'(bus.Conv_Busy), 32'd0);
        check("seqB_reset_valid", 32'(bus.Conv_Valid), 32'd0);
        check("seqB_reset_result", 32'(bus.Conv_Result), 32'd0);
        repeat (2) @(negedge clk);
        check("seqB_abort_no_valid", 32'(n_valid - v0), 32'd0);
        rst_n = 1'b1;                                    // ready is already high, so this counts as an edge
        sbq.push_back('{res: 16'h0321, cyc: 32'(cyc + 11)});
        @(negedge clk);
        bus.Conv_WinRdy = 1'b0;
        wait_done();
        check("seqB_single_valid", 32'(n_valid - v0), 32'd1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
